// File: rtl/switch_debounce.sv
// Synchronizes and debounces raw slide-switch lines; emits clean levels plus change pulses.
// Define SWITCH_DEBOUNCE_EDGE_EN to build the rise/fall/changed pulse registers.
//
// state | meaning
// IDLE  | cnt[i] == 0, s[i] matches dout[i]
// PEND  | cnt[i] != 0, s[i] differs and is being timed toward DB_CYCLES
module switch_debounce #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             stable
);

    localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DB_CYCLES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The terminal-count compare only matters while the level still differs,
    // so a bounce on the final PEND cycle cancels instead of accepting.
    always_comb begin
        differ = s ^ dout;
        accept = '0;
        stable = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = differ[i] && (cnt[i] == DB_TC);
            if (cnt[i] != '0) stable = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]  <= '0;
                    dout[i] <= s[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            rise    <= accept & s;
            fall    <= accept & ~s;
            changed <= |accept;
        end
    end
`else
    assign rise    = '0;
    assign fall    = '0;
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce (WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4).
// Stimulus queues expected output events; a negedge monitor pops and compares them.
module tb_switch_debounce;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif
    // Sampling edge of a new din level to dout update: SYNC_STAGES + DB_CYCLES,
    // plus one because din is driven on the negedge before that sampling edge.
    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout, rise, fall;
    logic       changed, stable;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] dout;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] dout_prev = 8'h00;

    switch_debounce #(
        .WIDTH(8), .SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout),
        .rise(rise), .fall(fall), .changed(changed), .stable(stable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int at, input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
        ev_t e;
        e.cyc     = at;
        e.dout    = d;
        e.rise    = EDGE_EN ? r : 8'h00;
        e.fall    = EDGE_EN ? f : 8'h00;
        e.changed = EDGE_EN ? ((r | f) != 8'h00) : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            step(1);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: %0d events still pending", exp_q.size());
            exp_q.delete();
        end
        step(2);
        chk("stable_after_settle", 32'(stable), 32'd1);
    endtask

    // Monitor: any dout change or pulse is an output event and must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if ((dout !== dout_prev) || (|rise) || (|fall) || changed) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_event at cycle %0d: dout=%0h rise=%0h fall=%0h changed=%0b expected no event",
                             cyc, dout, rise, fall, changed);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("dout", 32'(dout), 32'(e.dout));
                    chk("rise", 32'(rise), 32'(e.rise));
                    chk("fall", 32'(fall), 32'(e.fall));
                    chk("changed", 32'(changed), 32'(e.changed));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                n_total++;
                n_bad++;
                $display("FAIL missed_event at cycle %0d: dout=%0h expected dout=%0h", cyc, dout, exp_q[0].dout);
                void'(exp_q.pop_front());
            end
        end
        dout_prev = dout;
    end

    initial begin
        int t;
        step(2);
        chk("reset_dout", 32'(dout), 32'h00);
        chk("reset_rise", 32'(rise), 32'h00);
        chk("reset_fall", 32'(fall), 32'h00);
        chk("reset_changed", 32'(changed), 32'd0);
        chk("reset_stable", 32'(stable), 32'd1);
        rst = 1'b1;

        // Quiet input: no events, always stable.
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("quiet_stable", 32'(stable), 32'd1);
        end
        chk("quiet_dout", 32'(dout), 32'h00);

        // Single bit rise.
        din = 8'h01;
        push(cyc + LAT, 8'h01, 8'h01, 8'h00);
        step(4);
        chk("pend_stable", 32'(stable), 32'd0);
        chk("pend_dout", 32'(dout), 32'h00);
        drain();

        // Bouncing bit 3 (3-cycle runs never reach acceptance), then a held 1.
        for (int k = 0; k < 2; k++) begin
            din = 8'h09;
            step(3);
            din = 8'h01;
            step(3);
        end
        chk("bounce_dout", 32'(dout), 32'h01);
        din = 8'h09;
        push(cyc + LAT, 8'h09, 8'h08, 8'h00);
        drain();

        // Falls on two bits together, then all bits rise together.
        din = 8'h00;
        push(cyc + LAT, 8'h00, 8'h00, 8'h09);
        drain();
        din = 8'hFF;
        push(cyc + LAT, 8'hFF, 8'hFF, 8'h00);
        drain();
        din = 8'h00;
        push(cyc + LAT, 8'h00, 8'h00, 8'hFF);
        drain();

        // Reset two cycles into PEND on bit 5 discards the pending transition.
        din = 8'h20;
        step(4);
        chk("pre_reset_stable", 32'(stable), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_reset_dout", 32'(dout), 32'h00);
        chk("mid_reset_stable", 32'(stable), 32'd1);
        chk("mid_reset_pulses", 32'({rise, fall, 7'd0, changed}), 32'h0);
        step(2);
        rst = 1'b1;
        t = cyc;
        push(t + LAT, 8'h20, 8'h20, 8'h00);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
